// File: rtl/snake_ring.sv
// snake_ring: snake body engine backed by a ring buffer of segment coordinates.
// Each accepted step computes the candidate head, scans the body for a self hit
// one RAM read per cycle, checks the grid edge (or wraps), and then either
// writes the new head at hp+1 or latches the collision and stops.
module snake_ring #(
    parameter int H        = 32,
    parameter int V        = 32,
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 3,
    parameter int WRAP     = 0,
    localparam int XW = $clog2(H),
    localparam int YW = $clog2(V),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    input  logic [1:0]    dir,
    input  logic          grow,
    output logic          busy,
    output logic          done,
    output logic          alive,
    output logic          self_col,
    output logic          wall_col,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] length,
    input  logic [LW-1:0] rd_idx,
    output logic [XW-1:0] rd_x,
    output logic [YW-1:0] rd_y,
    output logic          rd_valid
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int SW = LW + 1;
    localparam int DW = XW + YW;

    localparam logic [XW-1:0] X_MAX     = XW'(H - 1);
    localparam logic [XW-1:0] X_MID     = XW'(H / 2);
    localparam logic [YW-1:0] Y_MAX     = YW'(V - 1);
    localparam logic [YW-1:0] Y_MID     = YW'(V / 2);
    localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);
    localparam logic [LW-1:0] LEN_INIT  = LW'(INIT_LEN);
    localparam logic [LW-1:0] INIT_LAST = LW'(INIT_LEN - 1);
    localparam logic [AW-1:0] HP_INIT   = AW'(INIT_LEN - 1);
    localparam logic [AW-1:0] HP_LAST   = AW'(MAX_LEN - 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_CHECK, S_WRITE, S_DEAD} state_t;

    state_t        state;
    logic [DW-1:0] mem [MAX_LEN];
    logic [AW-1:0] hp, hp_next, scan_addr, rd_addr, wr_addr;
    logic [1:0]    cur_dir, eff_dir;
    logic [XW-1:0] nh_x, cand_x;
    logic [YW-1:0] nh_y, cand_y;
    logic          off_grid, wall_hit, grow_ok, grow_q, hit, wr_en;
    logic [LW-1:0] scan_cnt, scan_k, cand_k;
    logic [DW-1:0] wr_data, scan_q, rd_q;

    // Segment idx lives at (base - idx) mod MAX_LEN; MAX_LEN need not be a power of two.
    function automatic logic [AW-1:0] ring_addr(input logic [AW-1:0] base, input logic [LW-1:0] idx);
        logic [SW-1:0] sum;
        sum = SW'(base) + SW'(MAX_LEN) - SW'(idx);
        if (sum >= SW'(MAX_LEN))
            sum = sum - SW'(MAX_LEN);
        return AW'(sum);
    endfunction

    assign hp_next   = (hp == HP_LAST) ? '0 : hp + AW'(1);
    assign eff_dir   = ((dir ^ 2'd2) == cur_dir) ? cur_dir : dir;
    assign wall_hit  = off_grid && (WRAP == 0);
    assign grow_ok   = grow && (length < LEN_MAX);
    assign cand_k    = grow_ok ? length : length - LW'(1);
    assign scan_addr = ring_addr(hp, scan_cnt);
    assign rd_addr   = ring_addr(hp, rd_idx);
    assign rd_x      = rd_valid ? rd_q[DW-1:YW] : '0;
    assign rd_y      = rd_valid ? rd_q[YW-1:0] : '0;

    // Candidate head one cell away in the effective direction, wrapping at the edges.
    always_comb begin
        cand_x   = head_x;
        cand_y   = head_y;
        off_grid = 1'b0;
        case (eff_dir)
            2'd0: if (head_x == X_MAX) begin off_grid = 1'b1; cand_x = '0; end
                  else cand_x = head_x + XW'(1);
            2'd1: if (head_y == Y_MAX) begin off_grid = 1'b1; cand_y = '0; end
                  else cand_y = head_y + YW'(1);
            2'd2: if (head_x == '0) begin off_grid = 1'b1; cand_x = X_MAX; end
                  else cand_x = head_x - XW'(1);
            default: if (head_y == '0) begin off_grid = 1'b1; cand_y = Y_MAX; end
                  else cand_y = head_y - YW'(1);
        endcase
    end

    // Write port: initial body laid out during INIT, new head committed in WRITE.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = hp_next;
        wr_data = {nh_x, nh_y};
        if (state == S_INIT) begin
            wr_en   = 1'b1;
            wr_addr = AW'(scan_cnt);
            wr_data = {X_MID - XW'(INIT_LAST - scan_cnt), Y_MID};
        end else if (state == S_WRITE && !hit) begin
            wr_en = 1'b1;
        end
    end

    // Segment RAM write port, held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (wr_en && !reset)
            mem[wr_addr] <= wr_data;
    end

    // Two synchronous read ports: body scan for the FSM and the renderer lookup.
    always_ff @(posedge clk) begin
        scan_q <= mem[scan_addr];
        rd_q   <= mem[rd_addr];
    end

    // Renderer valid flag, registered alongside the read data.
    always_ff @(posedge clk) begin
        if (reset)
            rd_valid <= 1'b0;
        else
            rd_valid <= (rd_idx < length);
    end

    // Step controller: init, accept, scan the body, commit or die.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_INIT;
            scan_cnt <= '0;
            scan_k   <= '0;
            hp       <= HP_INIT;
            cur_dir  <= 2'd0;
            head_x   <= X_MID;
            head_y   <= Y_MID;
            nh_x     <= '0;
            nh_y     <= '0;
            length   <= LEN_INIT;
            busy     <= 1'b1;
            done     <= 1'b0;
            alive    <= 1'b1;
            self_col <= 1'b0;
            wall_col <= 1'b0;
            hit      <= 1'b0;
            grow_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_INIT: begin
                    if (scan_cnt == INIT_LAST) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        scan_cnt <= '0;
                    end else begin
                        scan_cnt <= scan_cnt + LW'(1);
                    end
                end
                S_IDLE: begin
                    if (step) begin
                        cur_dir <= eff_dir;
                        if (wall_hit) begin
                            wall_col <= 1'b1;
                            alive    <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_DEAD;
                        end else begin
                            nh_x     <= cand_x;
                            nh_y     <= cand_y;
                            scan_k   <= cand_k;
                            grow_q   <= grow_ok;
                            hit      <= 1'b0;
                            scan_cnt <= '0;
                            busy     <= 1'b1;
                            state    <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (scan_cnt != '0 && scan_q == {nh_x, nh_y})
                        hit <= 1'b1;
                    if (scan_cnt == scan_k)
                        state <= S_WRITE;
                    else
                        scan_cnt <= scan_cnt + LW'(1);
                end
                S_WRITE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (hit) begin
                        self_col <= 1'b1;
                        alive    <= 1'b0;
                        state    <= S_DEAD;
                    end else begin
                        hp     <= hp_next;
                        head_x <= nh_x;
                        head_y <= nh_y;
                        if (grow_q)
                            length <= length + LW'(1);
                        state <= S_IDLE;
                    end
                end
                default: state <= S_DEAD;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_ring.sv
// Bench for snake_ring: three instances (walled 32x32, wrapping 20x32, walled with a
// four-deep ring) driven by directed moves. A list model of the body predicts every
// step's outcome and timing; a negedge monitor compares the status outputs each cycle.
module tb_snake_ring;

    localparam int NI = 3;
    localparam int IL = 3;
    localparam int VV = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]      rst, step, grow;
    logic [NI-1:0][1:0] dir;
    logic [NI-1:0][6:0] rd_idx;

    wire [NI-1:0]      busy, done, alive, self_col, wall_col, rd_valid;
    wire [NI-1:0][4:0] hx, hy, rx, ry;
    wire [NI-1:0][6:0] len;
    wire [2:0]         len_c;
    assign len[2] = {4'b0000, len_c};

    snake_ring #(.H(32), .V(32), .MAX_LEN(64), .INIT_LEN(IL), .WRAP(0)) dut_a (
        .clk(clk), .reset(rst[0]), .step(step[0]), .dir(dir[0]), .grow(grow[0]),
        .busy(busy[0]), .done(done[0]), .alive(alive[0]), .self_col(self_col[0]),
        .wall_col(wall_col[0]), .head_x(hx[0]), .head_y(hy[0]), .length(len[0]),
        .rd_idx(rd_idx[0]), .rd_x(rx[0]), .rd_y(ry[0]), .rd_valid(rd_valid[0]));

    snake_ring #(.H(20), .V(32), .MAX_LEN(64), .INIT_LEN(IL), .WRAP(1)) dut_b (
        .clk(clk), .reset(rst[1]), .step(step[1]), .dir(dir[1]), .grow(grow[1]),
        .busy(busy[1]), .done(done[1]), .alive(alive[1]), .self_col(self_col[1]),
        .wall_col(wall_col[1]), .head_x(hx[1]), .head_y(hy[1]), .length(len[1]),
        .rd_idx(rd_idx[1]), .rd_x(rx[1]), .rd_y(ry[1]), .rd_valid(rd_valid[1]));

    snake_ring #(.H(32), .V(32), .MAX_LEN(4), .INIT_LEN(IL), .WRAP(0)) dut_c (
        .clk(clk), .reset(rst[2]), .step(step[2]), .dir(dir[2]), .grow(grow[2]),
        .busy(busy[2]), .done(done[2]), .alive(alive[2]), .self_col(self_col[2]),
        .wall_col(wall_col[2]), .head_x(hx[2]), .head_y(hy[2]), .length(len_c),
        .rd_idx(rd_idx[2][2:0]), .rd_x(rx[2]), .rd_y(ry[2]), .rd_valid(rd_valid[2]));

    int tests = 0;
    int fails = 0;

    int m_len [NI];
    int m_dir [NI];
    bit m_alive [NI];
    int sx [NI][64];
    int sy [NI][64];

    int e_busy [NI], e_done [NI], e_alive [NI], e_self [NI], e_wall [NI];
    int e_hx [NI], e_hy [NI], e_len [NI];
    bit chk_en [NI];

    function automatic int pH(input int i);
        return (i == 1) ? 20 : 32;
    endfunction

    function automatic int pML(input int i);
        return (i == 2) ? 4 : 64;
    endfunction

    function automatic bit pWrap(input int i);
        return (i == 1);
    endfunction

    task automatic checkOutput(input int i, input string name, input logic [31:0] act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s dut%0d: got %0d expected %0d", name, i, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison of every status output against the model expectations.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (chk_en[i]) begin
                checkOutput(i, "busy",     32'(busy[i]),     e_busy[i]);
                checkOutput(i, "done",     32'(done[i]),     e_done[i]);
                checkOutput(i, "alive",    32'(alive[i]),    e_alive[i]);
                checkOutput(i, "self_col", 32'(self_col[i]), e_self[i]);
                checkOutput(i, "wall_col", 32'(wall_col[i]), e_wall[i]);
                checkOutput(i, "head_x",   32'(hx[i]),       e_hx[i]);
                checkOutput(i, "head_y",   32'(hy[i]),       e_hy[i]);
                checkOutput(i, "length",   32'(len[i]),      e_len[i]);
            end
        end
    end

    task automatic doReset(input int i);
        rst[i]  = 1'b1;
        step[i] = 1'b0;
        tick();
        m_len[i]   = IL;
        m_dir[i]   = 0;
        m_alive[i] = 1'b1;
        for (int j = 0; j < IL; j++) begin
            sx[i][j] = pH(i) / 2 - j;
            sy[i][j] = VV / 2;
        end
        e_busy[i]  = 1;
        e_done[i]  = 0;
        e_alive[i] = 1;
        e_self[i]  = 0;
        e_wall[i]  = 0;
        e_hx[i]    = pH(i) / 2;
        e_hy[i]    = VV / 2;
        e_len[i]   = IL;
        chk_en[i]  = 1'b1;
        tick();
        rst[i] = 1'b0;
        repeat (IL) tick();
        e_busy[i] = 0;
    endtask

    task automatic applyStimulus(input int i, input int d, input int g);
        int  ed, nx, ny, k;
        bit  wall, hit, gok;
        dir[i]  = 2'(d);
        grow[i] = (g != 0);
        step[i] = 1'b1;
        if (!m_alive[i]) begin
            tick();
            step[i] = 1'b0;
            grow[i] = 1'b0;
            repeat (3) tick();
            return;
        end
        ed = ((d ^ 2) == m_dir[i]) ? m_dir[i] : d;
        m_dir[i] = ed;
        nx = sx[i][0];
        ny = sy[i][0];
        case (ed)
            0: nx = nx + 1;
            1: ny = ny + 1;
            2: nx = nx - 1;
            default: ny = ny - 1;
        endcase
        wall = (nx < 0) || (nx >= pH(i)) || (ny < 0) || (ny >= VV);
        if (pWrap(i)) begin
            wall = 1'b0;
            nx = (nx + pH(i)) % pH(i);
            ny = (ny + VV) % VV;
        end
        gok = (g != 0) && (m_len[i] < pML(i));
        k = gok ? m_len[i] : m_len[i] - 1;
        hit = 1'b0;
        for (int j = 0; j < k; j++)
            if (sx[i][j] == nx && sy[i][j] == ny)
                hit = 1'b1;
        tick();
        step[i] = 1'b0;
        grow[i] = 1'b0;
        if (wall) begin
            e_done[i]  = 1;
            e_alive[i] = 0;
            e_wall[i]  = 1;
            m_alive[i] = 1'b0;
            tick();
            e_done[i] = 0;
            return;
        end
        e_busy[i] = 1;
        repeat (k + 1) tick();
        tick();
        e_busy[i] = 0;
        e_done[i] = 1;
        if (hit) begin
            e_self[i]  = 1;
            e_alive[i] = 0;
            m_alive[i] = 1'b0;
        end else begin
            for (int j = (gok ? m_len[i] : m_len[i] - 1); j > 0; j--) begin
                sx[i][j] = sx[i][j-1];
                sy[i][j] = sy[i][j-1];
            end
            sx[i][0] = nx;
            sy[i][0] = ny;
            if (gok)
                m_len[i] = m_len[i] + 1;
            e_hx[i]  = nx;
            e_hy[i]  = ny;
            e_len[i] = m_len[i];
        end
        tick();
        e_done[i] = 0;
    endtask

    task automatic checkSeg(input int i, input int idx, input int ex, input int ey, input int ev);
        rd_idx[i] = 7'(idx);
        tick();
        checkOutput(i, "rd_valid", 32'(rd_valid[i]), ev);
        checkOutput(i, "rd_x",     32'(rx[i]),       ex);
        checkOutput(i, "rd_y",     32'(ry[i]),       ey);
    endtask

    task automatic checkSegModel(input int i, input int idx);
        if (idx < m_len[i])
            checkSeg(i, idx, sx[i][idx], sy[i][idx], 1);
        else
            checkSeg(i, idx, 0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = '0;
        step   = '0;
        grow   = '0;
        dir    = '0;
        rd_idx = '0;
        for (int i = 0; i < NI; i++) chk_en[i] = 1'b0;

        doReset(0);
        doReset(1);
        doReset(2);

        // Reset state and initial body layout
        checkOutput(0, "t1_length", 32'(len[0]), 3);
        checkOutput(0, "t1_head_x", 32'(hx[0]), 16);
        checkOutput(0, "t1_head_y", 32'(hy[0]), 16);
        checkSeg(0, 0, 16, 16, 1);
        checkSeg(0, 1, 15, 16, 1);
        checkSeg(0, 2, 14, 16, 1);
        checkSeg(0, 3, 0, 0, 0);

        // One move up, then a reversal attempt that keeps going up
        applyStimulus(0, 1, 0);
        checkOutput(0, "t2_head_x", 32'(hx[0]), 16);
        checkOutput(0, "t2_head_y", 32'(hy[0]), 17);
        checkOutput(0, "t2_length", 32'(len[0]), 3);
        checkSeg(0, 2, 15, 16, 1);
        applyStimulus(0, 3, 0);
        checkOutput(0, "t2_rev_head_y", 32'(hy[0]), 18);

        // Run into the right wall; later steps are ignored
        repeat (15) applyStimulus(0, 0, 0);
        checkOutput(0, "t3_head_x", 32'(hx[0]), 31);
        applyStimulus(0, 0, 0);
        checkOutput(0, "t3_wall_col", 32'(wall_col[0]), 1);
        checkOutput(0, "t3_alive", 32'(alive[0]), 0);
        checkOutput(0, "t3_head_x_kept", 32'(hx[0]), 31);
        applyStimulus(0, 1, 0);

        // Grow to five then curl back into the body
        doReset(0);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 2, 0);
        applyStimulus(0, 3, 0);
        checkOutput(0, "t5_self_col", 32'(self_col[0]), 1);
        checkOutput(0, "t5_alive", 32'(alive[0]), 0);
        checkOutput(0, "t5_length", 32'(len[0]), 5);

        // Same loop at length four: the tail cell is vacated in time
        doReset(0);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 2, 0);
        applyStimulus(0, 3, 0);
        checkOutput(0, "t5b_alive", 32'(alive[0]), 1);
        checkOutput(0, "t5b_head_x", 32'(hx[0]), 16);
        checkOutput(0, "t5b_head_y", 32'(hy[0]), 16);
        checkOutput(0, "t5b_length", 32'(len[0]), 4);
        for (int j = 0; j < 5; j++) checkSegModel(0, j);

        // Wrapping grid of width 20: right edge to 0, bottom edge to 31
        repeat (9) applyStimulus(1, 0, 0);
        checkOutput(1, "t4_head_x", 32'(hx[1]), 19);
        applyStimulus(1, 0, 0);
        checkOutput(1, "t4_wrap_x", 32'(hx[1]), 0);
        checkOutput(1, "t4_wall_col", 32'(wall_col[1]), 0);
        checkOutput(1, "t4_alive", 32'(alive[1]), 1);
        repeat (17) applyStimulus(1, 3, 0);
        checkOutput(1, "t4_wrap_y", 32'(hy[1]), 31);
        for (int j = 0; j < 4; j++) checkSegModel(1, j);

        // Four-deep ring: length saturates, then reset lands mid-scan
        repeat (3) applyStimulus(2, 0, 1);
        checkOutput(2, "t6_length_sat", 32'(len[2]), 4);
        checkOutput(2, "t6_head_x", 32'(hx[2]), 19);
        checkSeg(2, 3, 16, 16, 1);
        for (int j = 0; j < 5; j++) checkSegModel(2, j);
        step[2] = 1'b1;
        grow[2] = 1'b1;
        dir[2]  = 2'd0;
        tick();
        step[2] = 1'b0;
        grow[2] = 1'b0;
        e_busy[2] = 1;
        tick();
        tick();
        doReset(2);
        checkOutput(2, "t6_rst_length", 32'(len[2]), 3);
        checkOutput(2, "t6_rst_head_x", 32'(hx[2]), 16);
        checkOutput(2, "t6_rst_head_y", 32'(hy[2]), 16);
        checkSeg(2, 0, 16, 16, 1);
        checkSeg(2, 1, 15, 16, 1);
        checkSeg(2, 2, 14, 16, 1);
        checkSeg(2, 3, 0, 0, 0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
